four_input_or_gate_a: RTL and testbench

//  - Bitwise 4-input OR (e = a|b|c|d) across WIDTH lanes, with a combinational output.
//  - Also provides a registered copy of e, edge pulses, and a per-lane "which input fired" code.
//  - Leaf block used wherever several request/flag sources merge into one.

---
 rtl/four_input_or_pkg.sv | 16 +
 rtl/four_input_or_gate_a_or4_lane.sv | 77 +++++++
 rtl/four_input_or_gate_a.sv | 80 ++++++++
 tb/tb_four_input_or_gate_a.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/four_input_or_pkg.sv
// ----------------------------------------------------------------------------
// four_input_or_pkg
// Shared constants for the four-input OR block and its lanes.
//   SRC_A..SRC_D   : per-lane source codes reported on src_q (a has top priority)
//   CNT_W_DEFAULT  : default width of the optional lane-0 activity counter
// ----------------------------------------------------------------------------
package four_input_or_pkg;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    localparam int CNT_W_DEFAULT = 16;

endpackage : four_input_or_pkg

// File: rtl/four_input_or_gate_a_or4_lane.sv
// ----------------------------------------------------------------------------
// or4_lane
// One lane of the four-input OR: combinational OR plus registered copy,
// rise/fall pulses and a priority code of the lowest-lettered active input.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   a, b, c, d      : lane inputs
//   e               : combinational a|b|c|d
//   e_q             : e delayed by one clock
//   e_rise, e_fall  : one-cycle registered edge pulses of e
//   src_q           : registered source code (SRC_A when e is 0)
// ----------------------------------------------------------------------------
module or4_lane
    import four_input_or_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       e,
    output logic       e_q,
    output logic       e_rise,
    output logic       e_fall,
    output logic [1:0] src_q
);

    logic       e_s;
    logic [1:0] src_s;
    logic       e_q_r;
    logic       e_rise_r;
    logic       e_fall_r;
    logic [1:0] src_q_r;

    // Lane OR; purely combinational so it is valid with the clock stopped or in reset.
    assign e_s = a | b | c | d;
    assign e   = e_s;

    // Fixed-priority encode a > b > c > d; an idle lane reports SRC_A (code 0).
    always_comb begin
        src_s = SRC_A;
        if (a) begin
            src_s = SRC_A;
        end else if (b) begin
            src_s = SRC_B;
        end else if (c) begin
            src_s = SRC_C;
        end else if (d) begin
            src_s = SRC_D;
        end else begin
            src_s = SRC_A;
        end
    end

    // Registered copy, edge pulses and source code. Comparing against e_q_r
    // means the first edge after reset sees a previous value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q_r    <= 1'b0;
            e_rise_r <= 1'b0;
            e_fall_r <= 1'b0;
            src_q_r  <= SRC_A;
        end else begin
            e_q_r    <= e_s;
            e_rise_r <= e_s & ~e_q_r;
            e_fall_r <= ~e_s & e_q_r;
            src_q_r  <= src_s;
        end
    end

    assign e_q    = e_q_r;
    assign e_rise = e_rise_r;
    assign e_fall = e_fall_r;
    assign src_q  = src_q_r;

endmodule : or4_lane

// File: rtl/four_input_or_gate_a.sv
// ----------------------------------------------------------------------------
// four_input_or_gate_a
// Bitwise four-input OR across WIDTH independent lanes, used where several
// request/flag sources merge into one.
// Parameters:
//   WIDTH  : number of lanes
//   CNT_W  : activity counter width (only meaningful with the stats build)
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   a, b, c, d      : lane inputs, lane i uses bit i
//   e               : combinational a|b|c|d
//   e_q             : e registered (1-cycle latency)
//   e_rise, e_fall  : registered one-cycle edge pulses per lane
//   src_q           : 2 bits per lane, lowest-lettered active input (a=0..d=3)
//   act_cnt         : saturating count of lane-0 e_rise pulses
// Build option: define FOUR_INPUT_OR_GATE_A_STATS_EN to add act_cnt and its
// counter; without it the port and counter do not exist.
// ----------------------------------------------------------------------------
module four_input_or_gate_a
    import four_input_or_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     e,
    output logic [WIDTH-1:0]     e_q,
    output logic [WIDTH-1:0]     e_rise,
    output logic [WIDTH-1:0]     e_fall,
    output logic [2*WIDTH-1:0]   src_q
`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
    ,
    output logic [CNT_W-1:0]     act_cnt
`endif
);

    // Reject a counter width that cannot hold any count.
    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("four_input_or_gate_a: CNT_W must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        or4_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .a      (a[i]),
            .b      (b[i]),
            .c      (c[i]),
            .d      (d[i]),
            .e      (e[i]),
            .e_q    (e_q[i]),
            .e_rise (e_rise[i]),
            .e_fall (e_fall[i]),
            .src_q  (src_q[2*i+1:2*i])
        );
    end

`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
    logic [CNT_W-1:0] act_cnt_r;

    // Count lane-0 rise pulses, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt_r <= '0;
        end else if (e_rise[0] && (act_cnt_r != {CNT_W{1'b1}})) begin
            act_cnt_r <= act_cnt_r + CNT_W'(1);
        end else begin
            act_cnt_r <= act_cnt_r;
        end
    end

    assign act_cnt = act_cnt_r;
`endif

endmodule : four_input_or_gate_a

// File: tb/tb_four_input_or_gate_a.sv
// ----------------------------------------------------------------------------
// tb_four_input_or_gate_a
// Directed scoreboard bench for four_input_or_gate_a with WIDTH=4, CNT_W=4.
// The stimulus process pushes hand-computed expectations into a queue; the
// monitor process pops and compares them against the live DUT outputs.
// ----------------------------------------------------------------------------
module tb_four_input_or_gate_a;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic               clk;
    logic               clk_en;
    logic               rst_n;
    logic [WIDTH-1:0]   a, b, c, d;
    logic [WIDTH-1:0]   e, e_q, e_rise, e_fall;
    logic [2*WIDTH-1:0] src_q;
`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
    logic [CNT_W-1:0]   act_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string              name;
        logic [WIDTH-1:0]   e;
        bit                 chk_reg;
        logic [WIDTH-1:0]   e_q;
        logic [WIDTH-1:0]   e_rise;
        logic [WIDTH-1:0]   e_fall;
        logic [2*WIDTH-1:0] src_q;
    } exp_t;

    exp_t exp_q[$];

    four_input_or_gate_a #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .e      (e),
        .e_q    (e_q),
        .e_rise (e_rise),
        .e_fall (e_fall),
        .src_q  (src_q)
`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
        ,
        .act_cnt (act_cnt)
`endif
    );

    // Gated clock so the combinational sweep can run with the clock stopped.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input string name, input logic [3:0] ev, input logic [3:0] eq,
                        input logic [3:0] er, input logic [3:0] ef, input logic [7:0] sq);
        exp_t x;
        x.name = name; x.e = ev; x.chk_reg = 1'b1;
        x.e_q = eq; x.e_rise = er; x.e_fall = ef; x.src_q = sq;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare each queued expectation against the DUT as it is presented.
    initial begin
        exp_t x;
        forever begin
            wait (exp_q.size() != 0);
            x = exp_q.pop_front();
            chk({x.name, ".e"}, 32'(e), 32'(x.e));
            if (x.chk_reg) begin
                chk({x.name, ".e_q"},    32'(e_q),    32'(x.e_q));
                chk({x.name, ".e_rise"}, 32'(e_rise), 32'(x.e_rise));
                chk({x.name, ".e_fall"}, 32'(e_fall), 32'(x.e_fall));
                chk({x.name, ".src_q"},  32'(src_q),  32'(x.src_q));
            end
        end
    end

    initial begin
        logic [3:0] code;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #1;

        // Exhaustive lane-0 sweep, clock stopped, reset held: d flips every 2ns, a every 16ns.
        for (int t = 0; t < 16; t++) begin
            code = 4'(t);
            a[0] = code[3]; b[0] = code[2]; c[0] = code[1]; d[0] = code[0];
            #1;
            push($sformatf("comb%0d", t), {3'b000, (code != 4'b0000)},
                 4'h0, 4'h0, 4'h0, 8'h00);
        end
        a = '0; b = '0; c = '0; d = '0;
`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
        chk("act_cnt_reset", 32'(act_cnt), 32'd0);
`endif

        clk_en = 1'b1;
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        push("idle", 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

        // Registered path on lane 0.
        a[0] = 1'b1;
        push("a_set_pre", 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
        tick(); push("a_rise",  4'h1, 4'h1, 4'h1, 4'h0, 8'h00);
        tick(); push("a_hold1", 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
        tick(); push("a_hold2", 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
        a[0] = 1'b0;
        tick(); push("a_fall",  4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
        tick(); push("a_quiet", 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

        // Priority and lane independence: lane0 0110, lane1 0001, lane2 1111, lane3 0000.
        a = 4'b0100; b = 4'b0101; c = 4'b0101; d = 4'b0110;
        tick(); push("prio1", 4'h7, 4'h7, 4'h7, 4'h0, 8'h0D);
        // lane0 1000, lane1 0100, lane2 0010, lane3 0001.
        a = 4'b0001; b = 4'b0010; c = 4'b0100; d = 4'b1000;
        tick(); push("prio2", 4'hF, 4'hF, 4'h8, 4'h0, 8'hE4);
        // Only lane3 active with c.
        a = 4'b0000; b = 4'b0000; c = 4'b1000; d = 4'b0000;
        tick(); push("prio3", 4'h8, 4'h8, 4'h0, 4'h7, 8'h80);
        c = 4'b0000;
        tick(); push("prio4", 4'h0, 4'h0, 4'h0, 4'h8, 8'h00);
        tick(); push("prio5", 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

        // Async reset mid-pulse, then first edge after release sees e_q as 0.
        b[0] = 1'b1;
        tick(); push("pre_rst", 4'h1, 4'h1, 4'h1, 4'h0, 8'h01);
        rst_n = 1'b0;
        #1;
        push("async_rst", 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
        tick(); push("rst_hold", 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
        rst_n = 1'b1;
        tick(); push("post_rst", 4'h1, 4'h1, 4'h1, 4'h0, 8'h01);
        b[0] = 1'b0;
        tick(); push("post_fall", 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
        tick();

`ifdef FOUR_INPUT_OR_GATE_A_STATS_EN
        // 20 lane-0 rising edges must leave a 4-bit counter saturated at 15.
        for (int k = 0; k < 20; k++) begin
            d[0] = 1'b1;
            tick();
            d[0] = 1'b0;
            tick();
        end
        tick();
        chk("act_cnt_sat", 32'(act_cnt), 32'd15);
`endif

        // Let the monitor drain, bounded.
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_four_input_or_gate_a
